// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction feeder.
package feeder_pkg;
  localparam int WORD_W = 10;
  localparam logic [WORD_W-1:0] NOP_WORD = 10'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } feeder_state_t;
endpackage

// File: rtl/instr_feeder_if.sv
// Processor / loader side of the feeder: program load, run control,
// external-data handshake and status.
interface instr_feeder_if #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic          LD_EN;
  logic [AW-1:0] LD_ADDR;
  logic [W-1:0]  LD_DATA;
  logic [AW-1:0] LAST;
  logic          START;
  logic          EXT;
  logic          CLR;
  logic [W-1:0]  DATA;
  logic [AW-1:0] PC;
  logic          BUSY;
  logic          DONE;
  logic          UNDERRUN;

  // Loader / processor end
  modport master (
    output LD_EN, LD_ADDR, LD_DATA, LAST, START, EXT, CLR,
    input  DATA, PC, BUSY, DONE, UNDERRUN
  );

  // Feeder end
  modport slave (
    input  LD_EN, LD_ADDR, LD_DATA, LAST, START, EXT, CLR,
    output DATA, PC, BUSY, DONE, UNDERRUN
  );
endinterface

// File: rtl/instr_feeder_prog_mem.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module prog_mem #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  // Write port; no reset so a program can be replayed after RST
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: presents program words to the processor's external
// data input, advancing one word per Ext and tracking completion via Clr.
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int W     = WORD_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLKb,
  input  logic          RST,
  instr_feeder_if.slave bus
);
  feeder_state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] last_q, last_d;
  logic [W-1:0]  data_q, data_d;
  logic          und_q, und_d;

  logic          mem_we;
  logic [AW-1:0] mem_raddr;
  logic [W-1:0]  mem_rdata;
  logic [AW-1:0] pc_inc;

  assign pc_inc = pc_q + AW'(1);
  // Single read port: next word while running, word 0 when (re)starting.
  // pc_inc may wrap at the last address but is never used there.
  assign mem_raddr = (state_q == RUN) ? pc_inc : '0;

  prog_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (CLKb),
    .we_i    (mem_we),
    .waddr_i (bus.LD_ADDR),
    .wdata_i (bus.LD_DATA),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // State register plus the prefetched DATA word
  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      data_q  <= '0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      data_q  <= data_d;
      und_q   <= und_d;
    end
  end

  // Next-state, PC/DATA advance, load enable and underrun tracking
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    data_d  = data_q;
    und_d   = und_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        mem_we = bus.LD_EN;
        if (bus.START) begin
          state_d = RUN;
          pc_d    = '0;
          last_d  = bus.LAST;
          und_d   = 1'b0;
          // Word 0 being written this very edge is forwarded directly
          data_d  = (bus.LD_EN && bus.LD_ADDR == '0) ? bus.LD_DATA : mem_rdata;
        end else if (state_q == FIN && bus.EXT) begin
          und_d = 1'b1;
        end
      end
      RUN: begin
        // CLR here is an intermediate instruction finishing: ignored
        if (bus.EXT) begin
          if (pc_q == last_q) begin
            state_d = DRAIN;
            data_d  = W'(NOP_WORD);
          end else begin
            pc_d   = pc_inc;
            data_d = mem_rdata;
          end
        end
      end
      DRAIN: begin
        if (bus.EXT) und_d = 1'b1;
        if (bus.CLR) state_d = FIN;
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        data_d  = W'(NOP_WORD);
      end
    endcase
  end

  assign bus.DATA     = data_q;
  assign bus.PC       = pc_q;
  assign bus.BUSY     = (state_q == RUN) || (state_q == DRAIN);
  assign bus.DONE     = (state_q == FIN);
  assign bus.UNDERRUN = und_q;
endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
Instruction/data source that drives the processor's 10-bit external data input in place of the slide switches. It holds a small loadable program memory and advances one word each time the processor consumes external data (Ext asserted on a clock edge). It tracks program completion through the processor's Clr (instruction done) signal. It is the responder end of the processor's external-data fetch, clocked by the same debounced step clock.

Parameters:
W, 10, data/instruction word width
DEPTH, 16, program memory words
AW, $clog2(DEPTH), address / PC width

Ports:
CLKb  input  1  step clock (debounced dbCLK); all state changes on rising edge
RST  input  1  asynchronous reset, active-high
LD_EN  input  1  write LD_DATA to mem[LD_ADDR]; honoured only in IDLE or FIN
LD_ADDR  input  AW  program load address
LD_DATA  input  W  program load word
LAST  input  AW  index of final program word (program length = LAST+1); sampled at START
START  input  1  begin or restart program from address 0
EXT  input  1  processor Ext: word on DATA is consumed at this edge
CLR  input  1  processor Clr: current instruction finished
DATA  output  W  word presented to processor data input
PC  output  AW  address of word currently on DATA
BUSY  output  1  high in RUN or DRAIN
DONE  output  1  high in FIN
UNDERRUN  output  1  sticky: EXT seen with no word available

Behaviour:
- Reset (async, RST=1): state IDLE; PC=0, DATA=0, DONE=0, BUSY=0, UNDERRUN=0, last_q=0. Memory contents are not reset.
- DATA is a register, prefetched from memory, so it is stable before the processor samples it. BUSY and DONE decode from the state.
- IDLE:
  - LD_EN writes the memory.
  - START: PC<=0, DATA<=mem[0], last_q<=LAST, UNDERRUN<=0, go to RUN.
  - START with LD_EN and LD_ADDR==0 in the same cycle: DATA<=LD_DATA (write bypass).
- RUN, EXT=1 edge:
  - If PC==last_q: DATA<=0, PC holds, go to DRAIN.
  - Else: PC<=PC+1, DATA<=mem[PC+1].
  - Zero latency: the next word is on DATA the cycle after consumption.
- RUN, other inputs:
  - EXT=0: hold.
  - CLR is ignored (it marks completion of intermediate instructions).
  - LD_EN and START are ignored.
- DRAIN:
  - Waits for the last instruction to complete; CLR=1 moves to FIN.
  - EXT=1 sets UNDERRUN; DATA stays 0.
  - EXT and CLR together: UNDERRUN set and move to FIN.
- FIN:
  - DONE=1; LD_EN honoured.
  - START restarts exactly as from IDLE.
  - EXT=1 sets UNDERRUN; DATA stays 0.
- EXT and CLR together in RUN: handled as EXT only.
- PC never wraps. LAST=DEPTH-1 consumes all DEPTH words, then enters DRAIN. Addresses beyond last_q are never presented.
- LAST changing mid-run has no effect (last_q is latched at START).
- RST mid-run aborts immediately to IDLE; memory is kept, so START replays the program.
- States: IDLE, RUN, DRAIN, FIN. Illegal state encodings return to IDLE.

Decomposition:
- Package feeder_pkg: state enum feeder_state_t {IDLE, RUN, DRAIN, FIN}; constant WORD_W=10; constant NOP_WORD=10'h000 (DATA value when no word is available).
- Sub-module prog_mem: DEPTH×W, synchronous write, asynchronous read, no reset. The FSM, PC and DATA register stay in instr_feeder.

Test Plan:
- Basic run:
  - Stimulus: load mem[0..2]=0x2A1,0x155,0x3FF with LAST=2; START; then EXT pulses on 3 separate edges.
  - Response: after START DATA=0x2A1 and PC=0; after the EXT pulses DATA=0x155 then 0x3FF, then DATA=0 in DRAIN with BUSY=1; CLR → DONE=1, BUSY=0.
- Underrun: EXT pulse in DRAIN, then another in FIN → UNDERRUN=1 and sticky, DATA=0; START → UNDERRUN=0, DATA=0x2A1.
- Ignored inputs in RUN: at PC=1, drive LD_EN addr2=0x000 and CLR=1 → state stays RUN, PC=1; the next EXT gives DATA=0x3FF (the write was ignored).
- Bypass: in IDLE, LD_EN addr0=0x0F0 together with START → the next cycle shows DATA=0x0F0, PC=0.
- Full depth: LAST=15 with 16 distinct words → 16 EXT pulses show each word in order; the 16th goes to DRAIN; PC stays at 15 and never wraps to 0.
- Reset mid-run: assert RST asynchronously at PC=1 → outputs go to zero immediately (before a clock edge); START → DATA=0x2A1 (memory retained).
